// File: rtl/regs_wb_scheduler.sv
// Writeback scheduler for the 32x32 integer register file: shares the single write
// port between the pipeline and a 2-entry multicycle result FIFO, and tracks pending registers.
module regs_wb_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_we,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd_chk,
    output logic        stall,
    output logic        pipe_hold,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy_vec,
    output logic [1:0]  fifo_count
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t      fifo_q [2];
    entry_t      fifo_d [2];
    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] busy_q, busy_d;
    logic [3:0]  starve_q, starve_d;

    logic   pipe_act;
    logic   fifo_empty;
    logic   drain;
    logic   enq;
    logic   wr_ptr;
    entry_t head_entry;

    assign pipe_act   = p_we && (p_addr != 5'd0);
    assign fifo_empty = (count_q == 2'd0);
    assign drain      = !pipe_act && !fifo_empty;
    assign head_entry = fifo_q[head_q];

    // Readiness is a decode of occupancy only, so a full FIFO never accepts even while draining.
    assign m_ready = (count_q != 2'd2);
    assign enq     = m_valid && m_ready && (m_addr != 5'd0);
    assign wr_ptr  = head_q ^ count_q[0];

    // Write port: the pipeline cannot be back-pressured, so it always wins.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (pipe_act) begin
            rf_we    = 1'b1;
            rf_waddr = p_addr;
            rf_wdata = p_data;
        end else if (!fifo_empty) begin
            rf_we    = 1'b1;
            rf_waddr = head_entry.addr;
            rf_wdata = head_entry.data;
        end
    end

    always_comb begin
        fifo_d = fifo_q;
        head_d = head_q;
        count_d = count_q;
        if (enq) begin
            fifo_d[wr_ptr] = '{addr: m_addr, data: m_data};
        end
        if (drain) begin
            head_d = ~head_q;
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Clear before set so a re-issue in the commit cycle keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (drain) begin
            busy_d[head_entry.addr] = 1'b0;
        end
        if (iss_valid && (iss_addr != 5'd0)) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || drain) begin
            starve_d = 4'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            head_q   <= 1'b0;
            count_q  <= 2'd0;
            busy_q   <= 32'd0;
            starve_q <= 4'd0;
        end else begin
            head_q   <= head_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign busy_vec   = busy_q;
    assign fifo_count = count_q;
    assign pipe_hold  = (starve_q == LIMIT);
    assign stall      = busy_q[rs1] | busy_q[rs2] | busy_q[rd_chk];

endmodule

// File: tb/tb_regs_wb_scheduler.sv
// Scoreboard bench for regs_wb_scheduler: expected register-file writes are queued by the
// stimulus and popped by a negedge monitor; state outputs are checked directly.
module tb_regs_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_we, m_valid, iss_valid;
    logic [4:0]  p_addr, m_addr, iss_addr, rs1, rs2, rd_chk;
    logic [31:0] p_data, m_data;
    logic        m_ready, stall, pipe_hold, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, busy_vec;
    logic [1:0]  fifo_count;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    regs_wb_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .rs1(rs1), .rs2(rs2), .rd_chk(rd_chk),
        .stall(stall), .pipe_hold(pipe_hold),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_vec(busy_vec), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the next queued expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected none", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("rf_waddr", {27'd0, rf_waddr}, {27'd0, e.a});
                check("rf_wdata", rf_wdata, e.d);
            end
        end
    end

    task automatic push(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic pw(input logic [4:0] a, input logic [31:0] d);
        p_we = 1'b1;
        p_addr = a;
        p_data = d;
        if (a != 5'd0) push(a, d);
    endtask

    task automatic mv(input logic [4:0] a, input logic [31:0] d);
        m_valid = 1'b1;
        m_addr = a;
        m_data = d;
    endtask

    task automatic iss(input logic [4:0] a);
        iss_valid = 1'b1;
        iss_addr = a;
    endtask

    // Advance to just after the next rising edge and drop all per-cycle strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        p_we = 1'b0; p_addr = '0; p_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    initial begin
        rst = 1'b1;
        p_we = 1'b0; p_addr = '0; p_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        iss_valid = 1'b0; iss_addr = '0;
        rs1 = '0; rs2 = '0; rd_chk = '0;

        // Reset state
        @(negedge clk);
        check("rst_m_ready", {31'd0, m_ready}, 32'd1);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_pipe_hold", {31'd0, pipe_hold}, 32'd0);
        check("rst_fifo_count", {30'd0, fifo_count}, 32'd0);
        check("rst_busy_vec", busy_vec, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        rst = 1'b0;

        // Idle drain of x5
        iss(5'd5);
        tick();
        mv(5'd5, 32'hDEADBEEF);
        rs1 = 5'd5;
        push(5'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("drain_busy_n", busy_vec, 32'h20);
        check("drain_stall_n", {31'd0, stall}, 32'd1);
        tick();
        @(negedge clk);
        check("drain_busy_n1", busy_vec, 32'h20);
        check("drain_stall_n1", {31'd0, stall}, 32'd1);
        check("drain_count_n1", {30'd0, fifo_count}, 32'd1);
        tick();
        @(negedge clk);
        check("drain_busy_n2", busy_vec, 32'd0);
        check("drain_stall_n2", {31'd0, stall}, 32'd0);
        check("drain_count_n2", {30'd0, fifo_count}, 32'd0);
        rs1 = 5'd0;
        tick();

        // Priority and backpressure with continuous pipeline writes
        pw(5'd3, 32'h100); mv(5'd10, 32'hA0);
        tick();
        pw(5'd3, 32'h101); mv(5'd11, 32'hA1);
        @(negedge clk);
        check("bp_ready_c1", {31'd0, m_ready}, 32'd1);
        tick();
        pw(5'd3, 32'h102); mv(5'd12, 32'hA2);
        @(negedge clk);
        check("bp_count_full", {30'd0, fifo_count}, 32'd2);
        check("bp_ready_full", {31'd0, m_ready}, 32'd0);
        tick();
        pw(5'd3, 32'h103);
        @(negedge clk);
        check("bp_hold_p3", {31'd0, pipe_hold}, 32'd0);
        tick();
        pw(5'd3, 32'h104);
        @(negedge clk);
        check("bp_hold_p4", {31'd0, pipe_hold}, 32'd0);
        tick();
        pw(5'd3, 32'h105);
        @(negedge clk);
        check("bp_hold_p5", {31'd0, pipe_hold}, 32'd1);
        tick();
        pw(5'd3, 32'h106);
        @(negedge clk);
        check("bp_hold_violate", {31'd0, pipe_hold}, 32'd1);
        check("bp_count_violate", {30'd0, fifo_count}, 32'd2);
        tick();
        push(5'd10, 32'hA0);
        @(negedge clk);
        check("bp_hold_drain1", {31'd0, pipe_hold}, 32'd1);
        tick();
        push(5'd11, 32'hA1);
        @(negedge clk);
        check("bp_hold_drain2", {31'd0, pipe_hold}, 32'd0);
        check("bp_count_drain2", {30'd0, fifo_count}, 32'd1);
        tick();
        @(negedge clk);
        check("bp_count_empty", {30'd0, fifo_count}, 32'd0);
        check("bp_ready_empty", {31'd0, m_ready}, 32'd1);
        tick();

        // x0 handling
        mv(5'd7, 32'h1234);
        tick();
        pw(5'd0, 32'hBAD0BAD0); mv(5'd0, 32'h5555); iss(5'd0);
        push(5'd7, 32'h1234);
        @(negedge clk);
        check("x0_count", {30'd0, fifo_count}, 32'd1);
        check("x0_ready", {31'd0, m_ready}, 32'd1);
        tick();
        @(negedge clk);
        check("x0_count_after", {30'd0, fifo_count}, 32'd0);
        check("x0_busy", busy_vec, 32'd0);
        tick();

        // Same-edge set and clear of x9
        iss(5'd9);
        tick();
        mv(5'd9, 32'h99);
        tick();
        iss(5'd9);
        push(5'd9, 32'h99);
        tick();
        @(negedge clk);
        check("setclr_busy", busy_vec, 32'h200);
        mv(5'd9, 32'h9A);
        tick();
        push(5'd9, 32'h9A);
        tick();
        @(negedge clk);
        check("setclr_busy_final", busy_vec, 32'd0);
        tick();

        // Simultaneous enqueue and dequeue at count 1
        mv(5'd13, 32'hD1);
        tick();
        mv(5'd14, 32'hD2);
        push(5'd13, 32'hD1);
        @(negedge clk);
        check("sim_count_before", {30'd0, fifo_count}, 32'd1);
        tick();
        push(5'd14, 32'hD2);
        @(negedge clk);
        check("sim_count_after", {30'd0, fifo_count}, 32'd1);
        tick();
        @(negedge clk);
        check("sim_count_empty", {30'd0, fifo_count}, 32'd0);
        tick();

        // Reset mid-stream
        iss(5'd5); pw(5'd2, 32'h200);
        tick();
        iss(5'd6); pw(5'd2, 32'h201); mv(5'd5, 32'h55);
        tick();
        pw(5'd2, 32'h202); mv(5'd6, 32'h66);
        tick();
        pw(5'd2, 32'h203);
        @(negedge clk);
        check("rs_count_full", {30'd0, fifo_count}, 32'd2);
        check("rs_busy_full", busy_vec, 32'h60);
        tick();
        rst = 1'b1;
        rs1 = 5'd5;
        @(negedge clk);
        check("rs_count", {30'd0, fifo_count}, 32'd0);
        check("rs_busy", busy_vec, 32'd0);
        check("rs_ready", {31'd0, m_ready}, 32'd1);
        check("rs_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("rs_idle_count", {30'd0, fifo_count}, 32'd0);
        tick();

        check("exp_queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
